// File: rtl/heart_model.sv
// heart_model: behavioural cardiac model for closed-loop pacemaker self-test.
// It produces intrinsic beats, accepts pacing pulses, and reports whether
// each pace captured a beat or landed in the refractory period.
// Optional build macro HEART_MODEL_JITTER_EN adds 0..15 ms of LFSR-driven
// variability to the intrinsic interval.
module heart_model #(
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned INTRINSIC_MS = 1000,
  parameter int unsigned REFRACT_MS   = 250,
  parameter int unsigned BEAT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] mode,
  input  logic       pace_in,
  output logic       beat_out,
  output logic       captured,
  output logic       refract_hit,
  output logic       beat_paced,
  output logic [7:0] beat_count
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW_W  = (BEAT_W > 1) ? $clog2(BEAT_W) : 1;
  localparam int unsigned MS_W  = 16;
  localparam int unsigned IV_W  = 18;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [BW_W-1:0]  BW_LAST   = BW_W'(BEAT_W - 1);
  localparam logic [IV_W-1:0]  IV_NORM   = IV_W'(INTRINSIC_MS);
  localparam logic [IV_W-1:0]  REFR_LIM  = IV_W'(REFRACT_MS);
  localparam logic [MS_W-1:0]  MS_MAX    = {MS_W{1'b1}};
  localparam logic [1:0]       MODE_BRADY = 2'b01;
  localparam logic [1:0]       MODE_ASYS  = 2'b10;
  localparam logic [1:0]       MODE_TACHY = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_BEAT    = 2'd2,
    S_REFRACT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;

  logic              pace_q;
  logic              rise_q;
  logic [PRE_W-1:0]  presc;
  logic [MS_W-1:0]   ms_cnt;
  logic [BW_W-1:0]   bcnt;

  logic              tick;
  logic [MS_W:0]     ms_inc;
  logic [IV_W-1:0]   ms_inc_w;
  logic [IV_W-1:0]   base_iv;
  logic [IV_W-1:0]   jitter;
  logic [IV_W-1:0]   interval;
  logic              enter_beat;
  logic              clear_cnt;

  logic              beat_out_n;
  logic              captured_n;
  logic              refract_hit_n;
  logic              beat_paced_n;
  logic [7:0]        beat_count_n;

`ifdef HEART_MODEL_JITTER_EN
  logic [7:0]        lfsr;

  // Heart-rate variability source: x^8+x^6+x^5+x^4+1, stepped once per beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 8'hA5;
    end else if (enter_beat) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign jitter = IV_W'(lfsr[3:0]);
`else
  assign jitter = '0;
`endif

  // 1 ms tick and ms counter with the +1 used by the expiry compares.
  assign tick     = (presc == PRE_LAST);
  assign ms_inc   = {1'b0, ms_cnt} + (MS_W + 1)'(1);
  assign ms_inc_w = IV_W'(ms_inc);

  // Intrinsic interval follows mode combinationally so a change acts at once.
  always_comb begin
    base_iv = IV_NORM;
    case (mode)
      MODE_BRADY: base_iv = IV_NORM << 1;
      MODE_TACHY: base_iv = IV_NORM >> 1;
      default:    base_iv = IV_NORM;
    endcase
    interval = base_iv + jitter;
  end

  // Next-state and next-output logic; enable low overrides everything.
  always_comb begin
    state_n       = state;
    enter_beat    = 1'b0;
    captured_n    = 1'b0;
    refract_hit_n = 1'b0;
    beat_paced_n  = beat_paced;
    beat_count_n  = beat_count;
    beat_out_n    = 1'b0;

    if (!enable) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (rise_q) begin
            state_n      = S_BEAT;
            enter_beat   = 1'b1;
            captured_n   = 1'b1;
            beat_paced_n = 1'b1;
          end else if ((mode != MODE_ASYS) && tick && (ms_inc_w >= interval)) begin
            state_n      = S_BEAT;
            enter_beat   = 1'b1;
            beat_paced_n = 1'b0;
          end
        end
        S_BEAT: begin
          if (bcnt == BW_LAST) begin
            state_n = S_REFRACT;
          end
        end
        S_REFRACT: begin
          refract_hit_n = rise_q;
          if (tick && (ms_inc_w >= REFR_LIM)) begin
            state_n = S_WAIT;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end

    if (enter_beat) begin
      beat_count_n = beat_count + 8'd1;
    end
    beat_out_n = (state_n == S_BEAT);
  end

  assign clear_cnt = (state_n != state) && ((state_n == S_WAIT) || (state_n == S_REFRACT));

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      beat_out    <= 1'b0;
      captured    <= 1'b0;
      refract_hit <= 1'b0;
      beat_paced  <= 1'b0;
      beat_count  <= 8'd0;
    end else begin
      state       <= state_n;
      beat_out    <= beat_out_n;
      captured    <= captured_n;
      refract_hit <= refract_hit_n;
      beat_paced  <= beat_paced_n;
      beat_count  <= beat_count_n;
    end
  end

  // Pace edge detect, registered so the FSM acts one cycle after sampling.
  always_ff @(posedge clk) begin
    if (reset) begin
      pace_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      pace_q <= pace_in;
      rise_q <= pace_in & ~pace_q;
    end
  end

  // Prescaler and saturating ms counter, restarted on WAIT/REFRACT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (clear_cnt) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else begin
      presc <= tick ? '0 : presc + PRE_W'(1);
      if (tick && (ms_cnt != MS_MAX)) begin
        ms_cnt <= ms_cnt + MS_W'(1);
      end
    end
  end

  // Beat width counter, restarted on every beat entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt <= '0;
    end else if (enter_beat) begin
      bcnt <= '0;
    end else if (state == S_BEAT) begin
      bcnt <= bcnt + BW_W'(1);
    end
  end

endmodule

// File: tb/tb_heart_model.sv
// tb_heart_model: directed table, multi-cycle sequences and random stimulus
// for heart_model, checked against a cycle-level behavioural model.
module tb_heart_model;

  localparam int TD  = 4;
  localparam int IMS = 10;
  localparam int RMS = 3;
  localparam int BW  = 2;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_BEAT = 2;
  localparam int P_REFR = 3;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic       pace_in;
  logic       beat_out;
  logic       captured;
  logic       refract_hit;
  logic       beat_paced;
  logic [7:0] beat_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  heart_model #(
    .TICK_DIV    (TD),
    .INTRINSIC_MS(IMS),
    .REFRACT_MS  (RMS),
    .BEAT_W      (BW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .pace_in    (pace_in),
    .beat_out   (beat_out),
    .captured   (captured),
    .refract_hit(refract_hit),
    .beat_paced (beat_paced),
    .beat_count (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase plus cycles spent in it; ms derived by division.
  typedef struct {
    int phase;
    int t;
    bit pace_prev;
    bit rise_d;
    bit beat;
    bit cap;
    bit rh;
    bit paced;
    int count;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, logic rst, logic en, logic [1:0] md, logic pace);
    model_t n;
    int iv;
    int ticks;
    bit is_tick;
    n = c;
    n.pace_prev = pace;
    n.rise_d = pace && !c.pace_prev;
    n.cap = 1'b0;
    n.rh = 1'b0;
    is_tick = ((c.t + 1) % TD) == 0;
    ticks = (c.t + 1) / TD;
    case (md)
      2'b01:   iv = IMS * 2;
      2'b11:   iv = IMS / 2;
      default: iv = IMS;
    endcase
    if (rst) begin
      n.phase = P_IDLE; n.t = 0; n.pace_prev = 1'b0; n.rise_d = 1'b0;
      n.paced = 1'b0; n.count = 0;
    end else if (!en) begin
      n.phase = P_IDLE; n.t = 0;
    end else begin
      case (c.phase)
        P_IDLE: begin n.phase = P_WAIT; n.t = 0; end
        P_WAIT: begin
          if (c.rise_d) begin
            n.phase = P_BEAT; n.t = 0; n.paced = 1'b1; n.cap = 1'b1;
            n.count = (c.count + 1) % 256;
          end else if (md != 2'b10 && is_tick && ticks >= iv) begin
            n.phase = P_BEAT; n.t = 0; n.paced = 1'b0;
            n.count = (c.count + 1) % 256;
          end else begin
            n.t = c.t + 1;
          end
        end
        P_BEAT: begin
          if (c.t + 1 >= BW) begin n.phase = P_REFR; n.t = 0; end
          else n.t = c.t + 1;
        end
        default: begin
          if (c.rise_d) n.rh = 1'b1;
          if (is_tick && ticks >= RMS) begin n.phase = P_WAIT; n.t = 0; end
          else n.t = c.t + 1;
        end
      endcase
    end
    n.beat = (n.phase == P_BEAT);
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, reset, enable, mode, pace_in);

  logic [11:0] dvec;
  logic [11:0] mvec;
  assign dvec = {beat_out, captured, refract_hit, beat_paced, beat_count};
  assign mvec = {m.beat, m.cap, m.rh, m.paced, 8'(m.count)};

  // One clock, then compare the DUT against the model at the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    n_cmp++;
    if (dvec !== mvec) begin
      n_bad++;
      $display("FAIL model cyc=%0d dut{beat,cap,rh,paced,cnt}=%b_%b_%b_%b_%0d want=%b_%b_%b_%b_%0d",
               cyc, dvec[11], dvec[10], dvec[9], dvec[8], dvec[7:0],
               mvec[11], mvec[10], mvec[9], mvec[8], mvec[7:0]);
    end
  endtask

  typedef struct {
    bit       rst;
    bit       en;
    bit [1:0] md;
    bit       pace;
    int       n;
    logic [11:0] exp;
    string    name;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(bit rst, bit en, bit [1:0] md, bit pace, int n,
                              bit b, bit c, bit r, bit p, int cnt, string name);
    row_t x;
    x.rst = rst; x.en = en; x.md = md; x.pace = pace; x.n = n;
    x.exp = {b, c, r, p, 8'(cnt)};
    x.name = name;
    return x;
  endfunction

  initial begin
    int rises;
    int budget;
    logic prev_beat;
    reset = 1'b1; enable = 1'b0; mode = 2'b00; pace_in = 1'b0;

    //               rst en md pace n    beat cap rh paced cnt
    tbl.push_back(mk(1, 0, 0, 0, 2,   0, 0, 0, 0, 0,  "reset"));
    tbl.push_back(mk(0, 1, 0, 0, 40,  0, 0, 0, 0, 0,  "wait40"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 1,  "first_beat41"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 1,  "beat_w2"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 0, 0, 1,  "beat_end"));
    tbl.push_back(mk(0, 1, 0, 0, 51,  0, 0, 0, 0, 1,  "pre_beat2"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 2,  "period54"));
    tbl.push_back(mk(0, 1, 3, 0, 33,  0, 0, 0, 0, 2,  "tachy_pre"));
    tbl.push_back(mk(0, 1, 3, 0, 1,   1, 0, 0, 0, 3,  "tachy34"));
    tbl.push_back(mk(0, 1, 1, 0, 93,  0, 0, 0, 0, 3,  "brady_pre"));
    tbl.push_back(mk(0, 1, 1, 0, 1,   1, 0, 0, 0, 4,  "brady94"));
    tbl.push_back(mk(0, 1, 2, 0, 33,  0, 0, 0, 0, 4,  "asys_wait"));
    tbl.push_back(mk(0, 1, 2, 1, 1,   0, 0, 0, 0, 4,  "pace_sampled"));
    tbl.push_back(mk(0, 1, 2, 0, 1,   1, 1, 0, 1, 5,  "paced_capture"));
    tbl.push_back(mk(0, 1, 2, 0, 1,   1, 0, 0, 1, 5,  "cap_one_cycle"));
    tbl.push_back(mk(0, 1, 2, 0, 1,   0, 0, 0, 1, 5,  "paced_beat_end"));
    tbl.push_back(mk(0, 1, 2, 0, 4,   0, 0, 0, 1, 5,  "refr_pre"));
    tbl.push_back(mk(0, 1, 2, 1, 1,   0, 0, 0, 1, 5,  "refr_pace"));
    tbl.push_back(mk(0, 1, 2, 0, 1,   0, 0, 1, 1, 5,  "refract_hit"));
    tbl.push_back(mk(0, 1, 2, 0, 1,   0, 0, 0, 1, 5,  "rh_one_cycle"));
    tbl.push_back(mk(0, 1, 2, 0, 4,   0, 0, 0, 1, 5,  "refr_tail"));
    tbl.push_back(mk(0, 1, 2, 1, 1,   0, 0, 0, 1, 5,  "refr_exit_no_hit"));
    tbl.push_back(mk(0, 1, 2, 0, 1,   1, 1, 0, 1, 6,  "wait_at_12"));
    tbl.push_back(mk(0, 1, 2, 0, 300, 0, 0, 0, 1, 6,  "asystole_hold"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 0, 1, 6,  "mode_chg_pre"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 7,  "mode_chg_now"));
    tbl.push_back(mk(0, 1, 0, 0, 52,  0, 0, 0, 0, 7,  "coinc_pre"));
    tbl.push_back(mk(0, 1, 0, 1, 1,   0, 0, 0, 0, 7,  "coinc_pace"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 1, 0, 1, 8,  "pace_and_expiry"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 1, 8,  "coinc_beat2"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   0, 0, 0, 1, 8,  "single_beat"));
    tbl.push_back(mk(0, 1, 0, 0, 51,  0, 0, 0, 1, 8,  "next_pre"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 9,  "next_intrinsic"));
    tbl.push_back(mk(0, 0, 0, 0, 1,   0, 0, 0, 0, 9,  "disable_mid_beat"));
    tbl.push_back(mk(0, 0, 0, 0, 5,   0, 0, 0, 0, 9,  "idle_hold"));
    tbl.push_back(mk(0, 1, 0, 0, 40,  0, 0, 0, 0, 9,  "reenable_wait"));
    tbl.push_back(mk(0, 1, 0, 0, 1,   1, 0, 0, 0, 10, "idle_restart41"));
    tbl.push_back(mk(1, 1, 0, 0, 1,   0, 0, 0, 0, 0,  "reset_mid_beat"));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; enable = tbl[i].en; mode = tbl[i].md; pace_in = tbl[i].pace;
      repeat (tbl[i].n) tick();
      n_cmp++;
      if (dvec !== tbl[i].exp) begin
        n_bad++;
        $display("FAIL %s: got {beat,cap,rh,paced,cnt}=%b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                 tbl[i].name, dvec[11], dvec[10], dvec[9], dvec[8], dvec[7:0],
                 tbl[i].exp[11], tbl[i].exp[10], tbl[i].exp[9], tbl[i].exp[8], tbl[i].exp[7:0]);
      end
    end

    // beat_count wrap over 256 tachycardia beats.
    reset = 1'b0; enable = 1'b1; mode = 2'b11; pace_in = 1'b0;
    rises = 0; budget = 0; prev_beat = 1'b0;
    while (rises < 256 && budget < 9000) begin
      tick();
      budget++;
      if (beat_out && !prev_beat) begin
        rises++;
        if (rises == 255) begin
          n_cmp++;
          if (beat_count !== 8'd255) begin
            n_bad++;
            $display("FAIL count_255: got %0d want 255", beat_count);
          end
        end
        if (rises == 256) begin
          n_cmp++;
          if (beat_count !== 8'd0) begin
            n_bad++;
            $display("FAIL count_wrap: got %0d want 0", beat_count);
          end
        end
      end
      prev_beat = beat_out;
    end
    if (rises < 256) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_timeout: got %0d beats want 256", rises);
    end

    // Random stimulus against the model.
    for (int k = 0; k < 20000; k++) begin
      reset = ($urandom_range(0, 999) == 0);
      if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      if ($urandom_range(0, 249) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) pace_in = ~pace_in;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
